// File: rtl/collision_event_scheduler.sv
// Per-frame collision event queue: captures first hit per source each frame, replays them next frame
// one at a time in priority order. Optional macro COLL_GAMEOVER_FLUSH_EN: source-0 hit flushes and freezes capture.

module collision_lane #(
  parameter int COORD_W = 11
)(
  input  logic               clk,
  input  logic               resetN,
  input  logic               swap,
  input  logic               req,
  input  logic [COORD_W-1:0] px,
  input  logic [COORD_W-1:0] py,
  input  logic               cap_en,
  input  logic               cap_clr,
  input  logic               iss_drop,
  input  logic               iss_clr,
  output logic               cap_set,
  output logic               iss_hit,
  output logic [COORD_W-1:0] iss_x,
  output logic [COORD_W-1:0] iss_y
);
  logic               cap_hit;
  logic [COORD_W-1:0] cap_x, cap_y;

  // a strobe in the swap cycle lands in the freshly cleared bank
  assign cap_set = req && cap_en && (swap || !cap_hit);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      cap_hit <= 1'b0;
      cap_x   <= '0;
      cap_y   <= '0;
      iss_hit <= 1'b0;
      iss_x   <= '0;
      iss_y   <= '0;
    end else begin
      if (cap_clr)      cap_hit <= 1'b0;
      else if (swap)    cap_hit <= cap_set;
      else if (cap_set) cap_hit <= 1'b1;
      if (cap_set) begin
        cap_x <= px;
        cap_y <= py;
      end
      if (swap) begin
        iss_hit <= cap_hit && !iss_drop;
        iss_x   <= cap_x;
        iss_y   <= cap_y;
      end else if (iss_drop || iss_clr) begin
        iss_hit <= 1'b0;
      end
    end
  end
endmodule

module collision_event_scheduler #(
  parameter int NUM_SRC    = 4,
  parameter int COORD_W    = 11,
  parameter int FRAME_ID_W = 4
)(
  input  logic                       clk,
  input  logic                       resetN,
  input  logic                       startOfFrame,
  input  logic [NUM_SRC-1:0]         coll_req,
  input  logic [COORD_W-1:0]         pixelX,
  input  logic [COORD_W-1:0]         pixelY,
  output logic                       evt_valid,
  input  logic                       evt_ready,
  output logic [$clog2(NUM_SRC)-1:0] evt_src,
  output logic [COORD_W-1:0]         evt_x,
  output logic [COORD_W-1:0]         evt_y,
  output logic [FRAME_ID_W-1:0]      evt_frame,
  output logic                       game_over,
  output logic                       overrun
);
  localparam int SRC_W = $clog2(NUM_SRC);

  typedef enum logic [1:0] {IDLE, ARB, PRESENT} state_t;
  state_t state;

  logic                            swap, hs, flush, cap_en, stale, sel_any;
  logic [NUM_SRC-1:0]              cap_set, iss_hit, iss_drop, iss_clr;
  logic [NUM_SRC-1:0]              iss_avail, inflight_oh, remaining;
  logic [NUM_SRC-1:0][COORD_W-1:0] iss_x, iss_y;
  logic [FRAME_ID_W-1:0]           frame_cnt, iss_frame;
  logic [SRC_W-1:0]                sel;

  assign swap = startOfFrame;
  assign hs   = evt_valid && evt_ready;

`ifdef COLL_GAMEOVER_FLUSH_EN
  assign flush  = cap_set[0];
  assign cap_en = !game_over;
`else
  assign flush  = 1'b0;
  assign cap_en = 1'b1;
`endif

  // stale: the presented event came from a bank replaced by a later swap, so its bit is gone
  assign inflight_oh = (state == PRESENT && !stale) ? (NUM_SRC'(1) << evt_src) : '0;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_lane
    localparam bit OTHER = (i != 0);
    assign iss_drop[i] = flush && OTHER && (swap || !inflight_oh[i]);
    assign iss_clr[i]  = hs && !swap && inflight_oh[i];

    collision_lane #(.COORD_W(COORD_W)) u_lane (
      .clk      (clk),
      .resetN   (resetN),
      .swap     (swap),
      .req      (coll_req[i]),
      .px       (pixelX),
      .py       (pixelY),
      .cap_en   (cap_en),
      .cap_clr  (flush && OTHER),
      .iss_drop (iss_drop[i]),
      .iss_clr  (iss_clr[i]),
      .cap_set  (cap_set[i]),
      .iss_hit  (iss_hit[i]),
      .iss_x    (iss_x[i]),
      .iss_y    (iss_y[i])
    );
  end

  assign iss_avail = iss_hit & ~iss_drop;
  assign remaining = iss_avail & ~inflight_oh;

  always_comb begin
    sel     = '0;
    sel_any = 1'b0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (iss_avail[i]) begin
        sel     = SRC_W'(i);
        sel_any = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state     <= IDLE;
      stale     <= 1'b0;
      evt_valid <= 1'b0;
      evt_src   <= '0;
      evt_x     <= '0;
      evt_y     <= '0;
      evt_frame <= '0;
      game_over <= 1'b0;
      overrun   <= 1'b0;
      frame_cnt <= '0;
      iss_frame <= '0;
    end else begin
      overrun <= swap && |(iss_hit & ~inflight_oh);
      if (cap_set[0]) game_over <= 1'b1;
      if (swap) begin
        frame_cnt <= frame_cnt + 1'b1;
        iss_frame <= frame_cnt;
      end
      case (state)
        IDLE: if (|iss_hit) state <= ARB;
        // a swap during arbitration re-arbitrates on the new bank
        ARB: begin
          if (swap) begin
            state <= ARB;
          end else if (sel_any) begin
            state     <= PRESENT;
            evt_valid <= 1'b1;
            evt_src   <= sel;
            evt_x     <= iss_x[sel];
            evt_y     <= iss_y[sel];
            evt_frame <= iss_frame;
            stale     <= 1'b0;
          end else begin
            state <= IDLE;
          end
        end
        PRESENT: begin
          if (hs) begin
            evt_valid <= 1'b0;
            state     <= (swap || |remaining) ? ARB : IDLE;
          end else if (swap) begin
            stale <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_collision_event_scheduler.sv
// Directed bench for collision_event_scheduler; inputs driven and outputs sampled on the falling edge.
// Test 6 expectations follow COLL_GAMEOVER_FLUSH_EN.

module tb_collision_event_scheduler;
  logic        clk = 1'b0;
  logic        resetN, startOfFrame, evt_ready;
  logic [3:0]  coll_req;
  logic [10:0] pixelX, pixelY;
  logic        evt_valid, game_over, overrun;
  logic [1:0]  evt_src;
  logic [10:0] evt_x, evt_y;
  logic [3:0]  evt_frame;
  int          n_cmp = 0;
  int          n_err = 0;

  collision_event_scheduler #(.NUM_SRC(4), .COORD_W(11), .FRAME_ID_W(4)) dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .coll_req(coll_req),
    .pixelX(pixelX), .pixelY(pixelY), .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_src(evt_src), .evt_x(evt_x), .evt_y(evt_y), .evt_frame(evt_frame),
    .game_over(game_over), .overrun(overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_evt(input string tag, input int src, input int x, input int y, input int fr);
    chk({tag, "_valid"}, 32'(evt_valid), 32'd1);
    chk({tag, "_src"},   32'(evt_src),   32'(src));
    chk({tag, "_x"},     32'(evt_x),     32'(x));
    chk({tag, "_y"},     32'(evt_y),     32'(y));
    chk({tag, "_frame"}, 32'(evt_frame), 32'(fr));
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic capture(input logic [3:0] req, input int x, input int y);
    coll_req = req; pixelX = 11'(x); pixelY = 11'(y);
    tick();
    coll_req = '0;
  endtask

  task automatic sof();
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
  endtask

  task automatic accept();
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
  endtask

  initial begin
    resetN = 1'b0; startOfFrame = 1'b0; coll_req = '0; pixelX = '0; pixelY = '0; evt_ready = 1'b0;
    repeat (3) tick();
    chk("rst_valid", 32'(evt_valid), 0);
    chk("rst_src",   32'(evt_src),   0);
    chk("rst_x",     32'(evt_x),     0);
    chk("rst_frame", 32'(evt_frame), 0);
    chk("rst_go",    32'(game_over), 0);
    chk("rst_ovr",   32'(overrun),   0);
    resetN = 1'b1;
    tick();

    // 1: two sources in one cycle, priority order, 3-cycle latency
    capture(4'b0110, 100, 50);
    sof();
    chk("t1_lat1", 32'(evt_valid), 0);
    chk("t1_ovr",  32'(overrun),   0);
    tick(); chk("t1_lat2", 32'(evt_valid), 0);
    tick(); chk_evt("t1_e1", 1, 100, 50, 0);
    accept(); chk("t1_bubble", 32'(evt_valid), 0);
    tick(); chk_evt("t1_e2", 2, 100, 50, 0);
    accept(); chk("t1_done0", 32'(evt_valid), 0);
    tick(); chk("t1_done1", 32'(evt_valid), 0);

    // 2: only the first pixel of a source is kept
    capture(4'b0100, 10, 10);
    capture(4'b0100, 20, 20);
    sof(); tick(); tick();
    chk_evt("t2", 2, 10, 10, 1);
    accept(); chk("t2_one0", 32'(evt_valid), 0);
    tick(); chk("t2_one1", 32'(evt_valid), 0);

    // 3: stalled consumer across a swap
    capture(4'b1010, 30, 40);
    sof(); tick(); tick();
    chk_evt("t3_first", 1, 30, 40, 2);
    capture(4'b0100, 7, 8);
    sof();
    chk("t3_ovr_on", 32'(overrun), 1);
    chk_evt("t3_held", 1, 30, 40, 2);
    tick();
    chk("t3_ovr_off", 32'(overrun), 0);
    chk("t3_still",   32'(evt_valid), 1);
    accept(); chk("t3_bubble", 32'(evt_valid), 0);
    tick(); chk_evt("t3_new", 2, 7, 8, 3);
    accept(); tick(); chk("t3_drop0", 32'(evt_valid), 0);
    tick(); chk("t3_drop1", 32'(evt_valid), 0);

    // 4: strobe coincident with startOfFrame belongs to the new frame
    coll_req = 4'b0010; pixelX = 11'd55; pixelY = 11'd66; startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0; coll_req = '0;
    tick(); tick(); chk("t4_notnow0", 32'(evt_valid), 0);
    tick(); chk("t4_notnow1", 32'(evt_valid), 0);
    sof(); tick(); tick();
    chk_evt("t4_next", 1, 55, 66, 5);
    accept();

    // 5: frame tag wraps 15 -> 0
    repeat (9) begin sof(); tick(); end
    capture(4'b1000, 1, 2);
    sof(); tick(); tick();
    chk_evt("t5_f15", 3, 1, 2, 15);
    accept();
    capture(4'b1000, 3, 4);
    sof(); tick(); tick();
    chk_evt("t5_f0", 3, 3, 4, 0);
    accept();

    // async reset while an event is presented
    capture(4'b0100, 12, 13);
    sof(); tick(); tick();
    chk("ar_pre", 32'(evt_valid), 1);
    capture(4'b0010, 8, 8);
    #2 resetN = 1'b0;
    #1;
    chk("ar_valid", 32'(evt_valid), 0);
    chk("ar_src",   32'(evt_src),   0);
    chk("ar_x",     32'(evt_x),     0);
    chk("ar_frame", 32'(evt_frame), 0);
    tick(); resetN = 1'b1;
    sof(); tick(); tick();
    chk("ar_cleared", 32'(evt_valid), 0);
    capture(4'b0010, 8, 9);
    sof(); tick(); tick();
    chk_evt("ar_after", 1, 8, 9, 1);
    accept();

    // 6: source 0 with source 3 pending
    capture(4'b1000, 5, 6);
    coll_req = 4'b0001; pixelX = 11'd9; pixelY = 11'd9;
    chk("t6_go_before", 32'(game_over), 0);
    tick();
    coll_req = '0;
    chk("t6_go_set", 32'(game_over), 1);
    sof(); tick(); tick();
    chk_evt("t6_src0", 0, 9, 9, 2);
    accept();
`ifdef COLL_GAMEOVER_FLUSH_EN
    chk("t6_flush0", 32'(evt_valid), 0);
    tick(); chk("t6_flush1", 32'(evt_valid), 0);
    tick(); chk("t6_flush2", 32'(evt_valid), 0);
    capture(4'b1000, 1, 1);
    sof(); tick(); tick();
    chk("t6_inhibit", 32'(evt_valid), 0);
`else
    tick(); chk_evt("t6_src3", 3, 5, 6, 2);
    accept();
    capture(4'b1000, 1, 1);
    sof(); tick(); tick();
    chk_evt("t6_later", 3, 1, 1, 3);
    accept();
`endif
    chk("t6_go_sticky", 32'(game_over), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
